// File: rtl/servo_pkg.sv
// Shared servo timing defaults and state encoding, used by the PWM generator
// and the motion controller.
package servo_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_HIGH = 2'd1;
  localparam logic [1:0] ENC_LOW  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_HIGH = ENC_HIGH,
    ST_LOW  = ENC_LOW
  } servo_state_e;

  // 4 us tick, 1 ms minimum pulse, 20 ms frame at 50 MHz
  localparam int unsigned SERVO_CLK_DIV     = 200;
  localparam int unsigned SERVO_BASE_TICKS  = 250;
  localparam int unsigned SERVO_FRAME_TICKS = 5000;
  localparam int unsigned SERVO_CNT_W       = 13;
  localparam int unsigned SERVO_RATIO_W     = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by CLK_DIV and emits a one-clock tick on the last count.
// A synchronous clear holds the counter at 0.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned DIV_EFF = (CLK_DIV < 1) ? 1 : CLK_DIV;
  localparam int unsigned PW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [PW-1:0] LAST  = PW'(DIV_EFF - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo-frame PWM generator: BASE_TICKS + ratio ticks high inside a FRAME_TICKS
// frame, ratio double-buffered at frame boundaries, pwm_done once per frame.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned CLK_DIV     = SERVO_CLK_DIV,
  parameter int unsigned BASE_TICKS  = SERVO_BASE_TICKS,
  parameter int unsigned FRAME_TICKS = SERVO_FRAME_TICKS,
  parameter int unsigned CNT_W       = SERVO_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     pwm_enable,
  input  logic [SERVO_RATIO_W-1:0] pwm_ratio,
  input  logic                     pwm_update,
  output logic                     pwm_done,
  output logic                     pwm_signal
);

  localparam int unsigned SUM_W = CNT_W + SERVO_RATIO_W + 1;
  typedef logic [SUM_W-1:0] sum_t;

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);

  // Wide add so the sum never wraps; clamped to leave at least one low tick
  // and at least one high tick per frame.
  function automatic logic [CNT_W-1:0] clamp_high_len(input logic [SERVO_RATIO_W-1:0] ratio);
    sum_t sum;
    sum = sum_t'(BASE_TICKS) + sum_t'(ratio);
    if (sum > sum_t'(FRAME_TICKS - 1)) begin
      sum = sum_t'(FRAME_TICKS - 1);
    end
    if (sum == '0) begin
      sum = sum_t'(1);
    end
    return sum[CNT_W-1:0];
  endfunction

  servo_state_e             state_q, state_d;
  logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
  logic [SERVO_RATIO_W-1:0] shadow_q, shadow_d;
  logic                     sig_q, sig_d;
  logic                     done_q, done_d;

  logic                     tick;
  logic                     presc_clr;
  logic [CNT_W-1:0]         high_last;
  logic                     frame_end;
  logic [CNT_W-1:0]         frame_cnt_adv;

  assign presc_clr = !pwm_enable || !((state_q == ST_HIGH) || (state_q == ST_LOW));

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clear_i (presc_clr),
    .tick_o  (tick)
  );

  assign high_last     = clamp_high_len(shadow_q) - CNT_W'(1);
  assign frame_end     = tick && (frame_cnt_q == FRAME_LAST);
  assign frame_cnt_adv = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    shadow_d    = shadow_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        frame_cnt_d = '0;
        if (pwm_enable) begin
          shadow_d = pwm_ratio;
          state_d  = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          frame_cnt_d = frame_cnt_adv;
          if (frame_cnt_q == high_last) begin
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (tick) begin
          frame_cnt_d = frame_cnt_adv;
        end
        if (frame_end) begin
          done_d  = 1'b1;
          state_d = ST_HIGH;
          if (pwm_update) begin
            shadow_d = pwm_ratio;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        frame_cnt_d = '0;
      end
    endcase

    // Disable overrides everything, including a coincident frame end.
    if (!pwm_enable) begin
      state_d     = ST_IDLE;
      frame_cnt_d = '0;
      shadow_d    = shadow_q;
      done_d      = 1'b0;
    end

    sig_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      shadow_q    <= '0;
      sig_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
      sig_q       <= sig_d;
      done_q      <= done_d;
    end
  end

  assign pwm_signal = sig_q;
  assign pwm_done   = done_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: frame widths, clamping, double buffering,
// disable and asynchronous reset behaviour.
module tb_servo_pwm_gen;

  typedef struct {
    int hi;
    int fl;
    int dn;
    int fd;
  } stats_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ratio;
  logic       upd;
  logic       sig_a, done_a;
  logic       sig_b, done_b;

  int checks;
  int failures;
  stats_t sa, sb;

  servo_pwm_gen #(
    .CLK_DIV     (2),
    .BASE_TICKS  (4),
    .FRAME_TICKS (300),
    .CNT_W       (13)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .pwm_enable (en),
    .pwm_ratio  (ratio),
    .pwm_update (upd),
    .pwm_done   (done_a),
    .pwm_signal (sig_a)
  );

  // Base length large enough that base + 255 exceeds the frame
  servo_pwm_gen #(
    .CLK_DIV     (2),
    .BASE_TICKS  (60),
    .FRAME_TICKS (300),
    .CNT_W       (13)
  ) dut_b (
    .clock      (clk),
    .reset_n    (rst_n),
    .pwm_enable (en),
    .pwm_ratio  (ratio),
    .pwm_update (upd),
    .pwm_done   (done_b),
    .pwm_signal (sig_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples n consecutive negedges: high count, first low index, done count,
  // first done index (-1 when absent).
  task automatic measure(input int n);
    sa = '{0, -1, 0, -1};
    sb = '{0, -1, 0, -1};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sig_a) sa.hi++; else if (sa.fl < 0) sa.fl = i;
      if (done_a) begin sa.dn++; if (sa.fd < 0) sa.fd = i; end
      if (sig_b) sb.hi++; else if (sb.fl < 0) sb.fl = i;
      if (done_b) begin sb.dn++; if (sb.fd < 0) sb.fd = i; end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    ratio = 8'd0;
    upd   = 1'b0;

    @(negedge clk);
    check("rst_sig_a", int'(sig_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_sig_b", int'(sig_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(10);
    check("idle_hi", sa.hi, 0);

    // Ratio 0: 8 clocks high, 592 low, done every 600 clocks
    ratio = 8'd0; upd = 1'b1; en = 1'b1;
    measure(600);
    check("s1_f1_hi", sa.hi, 8);
    check("s1_f1_fl", sa.fl, 8);
    check("s1_f1_dn", sa.dn, 0);
    check("s1_b_hi", sb.hi, 120);
    measure(600);
    check("s1_f2_dn", sa.dn, 1);
    check("s1_f2_fd", sa.fd, 0);
    check("s1_f2_hi", sa.hi, 8);
    check("s1_f2_fl", sa.fl, 8);
    check("s1_b_dn", sb.dn, 1);

    // Ratio 255: 518 high; BASE 60 instance clamps to 598 high, 2 low
    ratio = 8'd255;
    measure(600);
    check("s2_hi", sa.hi, 518);
    check("s2_fl", sa.fl, 518);
    check("s2_dn", sa.dn, 1);
    check("s2_b_hi", sb.hi, 598);
    check("s2_b_fl", sb.fl, 598);

    // Ratio 10 -> 100 mid-high with update
    ratio = 8'd10;
    measure(10);
    check("s3_pre_hi", sa.hi, 10);
    ratio = 8'd100;
    measure(590);
    check("s3_n_hi", sa.hi, 18);
    check("s3_n_fl", sa.fl, 18);
    measure(600);
    check("s3_n1_hi", sa.hi, 208);
    check("s3_n1_fl", sa.fl, 208);

    // Same change without update: stays at 28
    ratio = 8'd10;
    measure(10);
    ratio = 8'd100; upd = 1'b0;
    measure(590);
    check("s3u_n_hi", sa.hi, 18);
    measure(600);
    check("s3u_n1_hi", sa.hi, 28);
    check("s3u_n1_fl", sa.fl, 28);
    check("s3u_n1_dn", sa.dn, 1);

    // Disable during HIGH at clock 5
    measure(5);
    check("s4_pre_hi", sa.hi, 5);
    en = 1'b0;
    measure(20);
    check("s4_off_hi", sa.hi, 0);
    check("s4_off_dn", sa.dn, 0);
    check("s4_off_b_dn", sb.dn, 0);
    ratio = 8'd20; en = 1'b1;
    measure(600);
    check("s4_re_hi", sa.hi, 48);
    check("s4_re_fl", sa.fl, 48);
    check("s4_re_dn", sa.dn, 0);

    // Disable on the exact frame-end clock
    en = 1'b0;
    measure(20);
    check("s5_dn", sa.dn, 0);
    check("s5_b_dn", sb.dn, 0);
    check("s5_hi", sa.hi, 0);

    // Asynchronous reset between edges (A in LOW, B still HIGH)
    ratio = 8'd0; en = 1'b1;
    measure(100);
    check("s6_hi", sa.hi, 8);
    check("s6_b_hi", sb.hi, 100);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_sig_a", int'(sig_a), 0);
    check("s6_rst_sig_b", int'(sig_b), 0);
    check("s6_rst_done_a", int'(done_a), 0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure(10);
    check("s6_idle_hi", sa.hi, 0);
    check("s6_idle_b_hi", sb.hi, 0);
    ratio = 8'd5; upd = 1'b1; en = 1'b1;
    measure(600);
    check("s6_f1_hi", sa.hi, 18);
    check("s6_f1_fl", sa.fl, 18);
    check("s6_f1_dn", sa.dn, 0);
    check("s6_f1_b_hi", sb.hi, 130);
    measure(600);
    check("s6_f2_dn", sa.dn, 1);
    check("s6_f2_fd", sa.fd, 0);
    check("s6_f2_hi", sa.hi, 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
